// File: rtl/line_buffer_pkg.sv
// Shared types and width helpers for the line_buffer_stream slice.
package line_buffer_pkg;

   localparam int unsigned PIXEL_W = 8;

   typedef logic [PIXEL_W-1:0] pixel_t;

   typedef struct packed {
      logic sof;
      logic eol;
   } lb_ctrl_t;

   // Cause of the most recent line-length violation, kept for debug visibility.
   typedef enum logic [1:0] {
      ERR_NONE        = 2'd0,
      ERR_SHORT       = 2'd1,
      ERR_LONG        = 2'd2,
      ERR_SOF_MIDLINE = 2'd3
   } lb_err_e;

   // Width able to hold 0..max_width inclusive (cfg_width, column counter).
   function automatic int unsigned lb_cw(input int unsigned max_width);
      return $clog2(max_width + 1);
   endfunction

   // Address width for a memory of the given depth.
   function automatic int unsigned lb_aw(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/lb_line_ram.sv
// One stored row: single-port RAM, asynchronous read and registered write, so a
// same-cycle read of the written address returns the old contents.
module lb_line_ram
   import line_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_WIDTH  = 640
) (
   input  logic                        clk,
   input  logic                        i_we,
   input  logic [lb_aw(MAX_WIDTH)-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0]       i_wdata,
   output logic [DATA_WIDTH-1:0]       o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [MAX_WIDTH];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

endmodule

// File: rtl/line_buffer_stream.sv
// Streaming line buffer: emits the current pixel plus the same column of the previous
// NUM_LINES rows. Define LB_BORDER_REPLICATE_EN to replicate the top border.
module line_buffer_stream
   import line_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_WIDTH  = 640,
   parameter int unsigned NUM_LINES  = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [lb_cw(MAX_WIDTH)-1:0]       cfg_width,
   input  logic [DATA_WIDTH-1:0]             s_pixel,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic                              s_sof,
   input  logic                              s_eol,
   output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] m_column,
   output logic [NUM_LINES:0]                m_rows_valid,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic                              m_sof,
   output logic                              m_eol,
   output logic                              err_line_len
);

   localparam int unsigned CW = lb_cw(MAX_WIDTH);
   localparam int unsigned AW = lb_aw(MAX_WIDTH);
   localparam int unsigned RW = lb_cw(NUM_LINES);

   logic [CW-1:0]                         r_col;
   logic [CW-1:0]                         r_width;
   logic [RW-1:0]                         r_row;
   logic                                  r_m_valid;
   logic [(NUM_LINES+1)*DATA_WIDTH-1:0]   r_column;
   logic [NUM_LINES:0]                    r_rows_valid;
   lb_ctrl_t                              r_ctrl;
   lb_err_e                               r_err;

   logic                                  w_accept;
   logic                                  w_we;
   logic [CW-1:0]                         w_cfg_eff;
   logic [CW-1:0]                         w_col;
   logic [CW-1:0]                         w_width;
   logic [RW-1:0]                         w_row;
   logic [RW-1:0]                         w_row_inc;
   logic                                  w_last;
   logic                                  w_wrap;
   lb_err_e                               w_err;
   logic [AW-1:0]                         w_addr;
   logic [NUM_LINES:0]                    w_rows_valid;
   logic [(NUM_LINES+1)*DATA_WIDTH-1:0]   w_column;
   logic [DATA_WIDTH-1:0]                 w_rdata [NUM_LINES];
   logic [DATA_WIDTH-1:0]                 w_tap   [NUM_LINES+1];

   assign s_ready  = !r_m_valid || m_ready;
   assign w_accept = s_valid && s_ready;
   assign w_we     = w_accept && !rst;

   assign w_cfg_eff = ((cfg_width == '0) || (cfg_width > CW'(MAX_WIDTH))) ? CW'(MAX_WIDTH) : cfg_width;

   // An accepted s_sof beat is handled as column 0 of row 0 with a freshly sampled width.
   assign w_col     = s_sof ? '0 : r_col;
   assign w_width   = s_sof ? w_cfg_eff : r_width;
   assign w_row     = s_sof ? '0 : r_row;
   assign w_row_inc = (w_row == RW'(NUM_LINES)) ? w_row : w_row + RW'(1);
   assign w_last    = (w_col == w_width - CW'(1));
   assign w_wrap    = s_eol || w_last;
   assign w_addr    = w_col[AW-1:0];

   always_comb begin
      w_err = ERR_NONE;
      if (s_sof && (r_col != '0)) begin
         w_err = ERR_SOF_MIDLINE;
      end else if (s_eol && !w_last) begin
         w_err = ERR_SHORT;
      end else if (!s_eol && w_last) begin
         w_err = ERR_LONG;
      end
   end

   // Row k of the cascade holds the column as it was k+1 lines ago.
   always_comb begin
      w_tap[0] = s_pixel;
      for (int unsigned k = 1; k <= NUM_LINES; k++) begin
         w_tap[k] = w_rdata[k-1];
      end
   end

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      lb_line_ram #(
         .DATA_WIDTH (DATA_WIDTH),
         .MAX_WIDTH  (MAX_WIDTH)
      ) u_ram (
         .clk     (clk),
         .i_we    (w_we),
         .i_addr  (w_addr),
         .i_wdata (w_tap[g]),
         .o_rdata (w_rdata[g])
      );
   end

   always_comb begin
      w_rows_valid = '0;
      w_column     = '0;
      for (int unsigned k = 0; k <= NUM_LINES; k++) begin
         w_rows_valid[k] = (32'(w_row) >= k);
`ifdef LB_BORDER_REPLICATE_EN
         w_column[k*DATA_WIDTH +: DATA_WIDTH] = w_rows_valid[k] ? w_tap[k] : w_tap[w_row];
`else
         w_column[k*DATA_WIDTH +: DATA_WIDTH] = w_rows_valid[k] ? w_tap[k] : '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col        <= '0;
         r_row        <= '0;
         r_width      <= w_cfg_eff;
         r_m_valid    <= 1'b0;
         r_column     <= '0;
         r_rows_valid <= '0;
         r_ctrl       <= '0;
         r_err        <= ERR_NONE;
      end else begin
         r_err <= w_accept ? w_err : ERR_NONE;
         if (w_accept) begin
            r_m_valid    <= 1'b1;
            r_column     <= w_column;
            r_rows_valid <= w_rows_valid;
            r_ctrl.sof   <= s_sof;
            r_ctrl.eol   <= w_wrap;
            r_width      <= w_width;
            if (w_wrap) begin
               r_col <= '0;
               r_row <= w_row_inc;
            end else begin
               r_col <= w_col + CW'(1);
               r_row <= w_row;
            end
         end else if (m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign m_valid      = r_m_valid;
   assign m_column     = r_column;
   assign m_rows_valid = r_rows_valid;
   assign m_sof        = r_ctrl.sof;
   assign m_eol        = r_ctrl.eol;
   assign err_line_len = (r_err != ERR_NONE);

endmodule

// File: tb/tb_line_buffer_stream.sv
// Self-checking bench for line_buffer_stream (MAX_WIDTH=16, NUM_LINES=2); honours
// LB_BORDER_REPLICATE_EN in its reference model.
module tb_line_buffer_stream;

   localparam int DW   = 8;
   localparam int MW   = 16;
   localparam int NL   = 2;
   localparam int CW   = $clog2(MW + 1);
   localparam int COLW = (NL + 1) * DW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [CW-1:0]     cfg_width = CW'(10);
   logic [DW-1:0]     s_pixel = '0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic              s_sof = 1'b0;
   logic              s_eol = 1'b0;
   logic [COLW-1:0]   m_column;
   logic [NL:0]       m_rows_valid;
   logic              m_valid;
   logic              m_ready = 1'b1;
   logic              m_sof;
   logic              m_eol;
   logic              err_line_len;

   line_buffer_stream #(
      .DATA_WIDTH (DW),
      .MAX_WIDTH  (MW),
      .NUM_LINES  (NL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_width    (cfg_width),
      .s_pixel      (s_pixel),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_sof        (s_sof),
      .s_eol        (s_eol),
      .m_column     (m_column),
      .m_rows_valid (m_rows_valid),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_sof        (m_sof),
      .m_eol        (m_eol),
      .err_line_len (err_line_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [COLW-1:0] col;
      logic [NL:0]     rv;
      logic            sof;
      logic            eol;
   } beat_t;

   // Reference model: per-column history of written pixels, newest first.
   logic [DW-1:0] hist [MW][$];
   beat_t         expq [$];
   int            mcol, mrow, mwidth;
   logic          pend_err = 1'b0;
   int            checks = 0;
   int            failures = 0;
   int            rmode = 0;
   int            err_cnt = 0;
   bit            acc_flag;
   bit            cap_en = 0;
   bit            first_pending = 0;
   logic [COLW-1:0] cap_col [50];
   logic [NL:0]     cap_rv  [50];
   logic [COLW-1:0] last_col;
   logic [NL:0]     last_rv;
   logic [NL:0]     first_rv;
   int              e0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic int eff(input int c);
      return (c == 0 || c > MW) ? MW : c;
   endfunction

   task automatic model_accept(input logic [DW-1:0] pix, input logic sof, input logic eol);
      beat_t b;
      logic [DW-1:0] s [NL+1];
      logic last, err;
      err = 1'b0;
      if (sof) begin
         err    = (mcol != 0);
         mcol   = 0;
         mrow   = 0;
         mwidth = eff(int'(cfg_width));
      end
      last = (mcol == mwidth - 1);
      if (eol != last) err = 1'b1;
      s[0] = pix;
      for (int k = 1; k <= NL; k++)
         s[k] = (k <= mrow && hist[mcol].size() >= k) ? hist[mcol][k-1] : '0;
`ifdef LB_BORDER_REPLICATE_EN
      for (int k = 1; k <= NL; k++)
         if (k > mrow) s[k] = s[mrow];
`endif
      b.col = '0;
      for (int k = 0; k <= NL; k++) begin
         b.rv[k] = (k <= mrow);
         b.col[k*DW +: DW] = s[k];
      end
      hist[mcol].push_front(pix);
      if (hist[mcol].size() > NL) void'(hist[mcol].pop_back());
      b.sof = sof;
      b.eol = eol || last;
      if (eol || last) begin
         mcol = 0;
         if (mrow < NL) mrow++;
      end else begin
         mcol++;
      end
      expq.push_back(b);
      pend_err = err;
   endtask

   task automatic cycle();
      beat_t b;
      case (rmode)
         0: m_ready = 1'b1;
         1: m_ready = ~m_ready;
         2: m_ready = 1'($urandom_range(0, 1));
         default: m_ready = 1'b0;
      endcase
      @(negedge clk);
      chk("err_line_len", err_line_len, pend_err);
      pend_err = 1'b0;
      if (err_line_len === 1'b1) err_cnt++;
      chk("m_valid", m_valid, expq.size() != 0);
      chk("s_ready", s_ready, (expq.size() == 0) || m_ready);
      if (m_valid === 1'b1 && m_ready && expq.size() != 0) begin
         b = expq.pop_front();
         chk("m_column", m_column, b.col);
         chk("m_rows_valid", m_rows_valid, b.rv);
         chk("m_sof", m_sof, b.sof);
         chk("m_eol", m_eol, b.eol);
         last_col = m_column;
         last_rv  = m_rows_valid;
         if (cap_en && b.col[DW-1:0] < 50) begin
            cap_col[b.col[DW-1:0]] = m_column;
            cap_rv[b.col[DW-1:0]]  = m_rows_valid;
         end
         if (first_pending) begin
            first_rv      = m_rows_valid;
            first_pending = 0;
         end
      end
      if (rst) begin
         expq.delete();
         mcol     = 0;
         mrow     = 0;
         mwidth   = eff(int'(cfg_width));
         pend_err = 1'b0;
      end else if (s_valid && s_ready) begin
         model_accept(s_pixel, s_sof, s_eol);
         acc_flag = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [DW-1:0] pix, input logic sof, input logic eol);
      int n;
      if (rmode == 2 && $urandom_range(0, 3) == 0) begin
         s_valid = 1'b0;
         cycle();
      end
      s_pixel  = pix;
      s_sof    = sof;
      s_eol    = eol;
      s_valid  = 1'b1;
      acc_flag = 0;
      n = 0;
      while (!acc_flag && n < 50) begin
         cycle();
         n++;
      end
      if (!acc_flag) begin
         checks++;
         failures++;
         $error("FAIL accept_timeout observed=not_accepted expected=accepted");
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_eol   = 1'b0;
   endtask

   task automatic flush();
      int n;
      s_valid = 1'b0;
      n = 0;
      while (expq.size() != 0 && n < 50) begin
         cycle();
         n++;
      end
      cycle();
      chk("drain", expq.size(), 0);
   endtask

   initial begin
      int pc, pw;
      logic sof, eol;
      int cfgs [6] = '{0, 3, 7, 16, 20, 5};

      // Reset with cfg_width = 0 (treated as MAX_WIDTH), then prefill every column.
      cfg_width = '0;
      @(posedge clk);
      #1;
      chk("reset_m_valid", m_valid, 0);
      chk("reset_m_column", m_column, 0);
      chk("reset_rows_valid", m_rows_valid, 0);
      chk("reset_err", err_line_len, 0);
      repeat (2) cycle();
      rst = 1'b0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < MW; c++)
            send_beat(8'(200 + c), (r == 0 && c == 0), (c == MW - 1));
      flush();

      // Pixels 0..49, width 10, m_ready held high.
      cfg_width = CW'(10);
      e0 = err_cnt;
      cap_en = 1;
      for (int p = 0; p < 50; p++) send_beat(8'(p), (p == 0), (p % 10 == 9));
      flush();
      cap_en = 0;
      chk("s1_no_err", err_cnt - e0, 0);
`ifdef LB_BORDER_REPLICATE_EN
      chk("s1_pix3_col", cap_col[3], 24'h030303);
      chk("s1_pix12_col", cap_col[12], 24'h02020c);
      chk("s1_pix3_rv", cap_rv[3], 3'b001);
`else
      chk("s1_pix25_col", cap_col[25], 24'h050f19);
      chk("s1_pix25_rv", cap_rv[25], 3'b111);
      chk("s1_pix12_rv", cap_rv[12], 3'b011);
      chk("s1_pix12_slice2", cap_col[12][23:16], 8'h00);
`endif

      // Same stream under alternating backpressure.
      rmode = 1;
      e0 = err_cnt;
      for (int p = 0; p < 50; p++) send_beat(8'(p), (p == 0), (p % 10 == 9));
      flush();
      chk("s2_no_err", err_cnt - e0, 0);

      // Short line: s_eol at column 7 of row 1.
      rmode = 2;
      e0 = err_cnt;
      for (int c = 0; c < 10; c++) send_beat(8'(100 + c), (c == 0), (c == 9));
      for (int c = 0; c < 8; c++) send_beat(8'(120 + c), 1'b0, (c == 7));
      send_beat(8'd140, 1'b0, 1'b0);
      flush();
      chk("s3_err_pulses", err_cnt - e0, 1);
      chk("s3_next_rv", last_rv, 3'b111);
      chk("s3_next_col", last_col, 24'h64788c);

      // s_sof mid-row at column 4.
      rmode = 0;
      for (int c = 0; c < 10; c++) send_beat(8'(150 + c), (c == 0), (c == 9));
      for (int c = 0; c < 4; c++) send_beat(8'(170 + c), 1'b0, 1'b0);
      flush();
      e0 = err_cnt;
      send_beat(8'd200, 1'b1, 1'b0);
      flush();
      chk("s4_err_pulses", err_cnt - e0, 1);
      chk("s4_sof_rv", last_rv, 3'b001);
      for (int c = 1; c < 10; c++) send_beat(8'(200 + c), 1'b0, (c == 9));
      for (int c = 0; c < 6; c++) send_beat(8'(210 + c), 1'b0, 1'b0);
      flush();
      chk("s4_rebuild_rv", last_rv, 3'b011);
      chk("s4_rebuild_slice1", last_col[15:8], 8'hcd);

      // Reset pulse while pixel 22 is held in the output register.
      for (int p = 0; p < 23; p++) send_beat(8'(p), (p == 0), (p % 10 == 9));
      rmode   = 3;
      s_pixel = 8'd23;
      s_valid = 1'b1;
      rst     = 1'b1;
      cycle();
      rst   = 1'b0;
      rmode = 0;
      s_valid = 1'b0;
      cycle();
      first_pending = 1;
      for (int p = 23; p < 50; p++) send_beat(8'(p), 1'b0, (p % 10 == 9));
      flush();
      chk("s5_first_rv", first_rv, 3'b001);

      // Randomised frames: varying widths, occasional wrong eol, random gaps and backpressure.
      rmode = 2;
      cfg_width = CW'(7);
      send_beat(8'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         sof = ($urandom_range(0, 39) == 0);
         if (sof) cfg_width = CW'(cfgs[$urandom_range(0, 5)]);
         pc  = sof ? 0 : mcol;
         pw  = sof ? eff(int'(cfg_width)) : mwidth;
         eol = (pc == pw - 1);
         if ($urandom_range(0, 19) == 0) eol = ~eol;
         send_beat(8'($urandom), sof, eol);
      end
      flush();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/line_buffer_stream.md
Name: line_buffer_stream

Overview:
- Parametrised successor to the vision front-end line buffer.
- Accepts a raster pixel stream with frame/line markers through a valid/ready handshake.
- Emits a vertical column of NUM_LINES+1 pixels: the current pixel plus the same column from each of the previous NUM_LINES rows, with per-row validity flags.
- Sits between the camera/ISP ingress and windowed filters (Sobel, Gaussian, etc.). Adds runtime line width, backpressure, and line-length error detection.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- MAX_WIDTH, 640, maximum pixels per line; sizes the line storage.
- NUM_LINES, 2, number of delayed rows stored (≥1).
- CW, $clog2(MAX_WIDTH+1), derived width of cfg_width and column counter. Localparam, not overridable.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_width  in  CW  active line width; sampled at reset release and on each accepted s_sof beat
- s_pixel  in  DATA_WIDTH  input pixel
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat
- s_sof  in  1  first pixel of frame
- s_eol  in  1  last pixel of line
- m_column  out  (NUM_LINES+1)*DATA_WIDTH  slice k = pixel k rows above current; slice 0 = current pixel
- m_rows_valid  out  NUM_LINES+1  bit k = slice k holds real data
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_sof, m_eol  out  1  markers aligned to m_column
- err_line_len  out  1  one-cycle pulse on line-length violation

Behaviour:
- Accept event: s_valid && s_ready. Output transfer: m_valid && m_ready. s_ready = !m_valid || m_ready, so no input is lost under backpressure.
- Latency: exactly 1 cycle from accepted input to m_valid. The output register holds stable while m_valid && !m_ready.
- Reset values: m_valid, m_column, m_rows_valid, m_sof, m_eol and err_line_len are all 0. Column counter and row counter are 0, and the active width is loaded from cfg_width. Line storage contents are not reset.
- Effective width W: cfg_width, or MAX_WIDTH if cfg_width is 0 or > MAX_WIDTH.
- On each accept at column c:
  - m_column slice 0 = s_pixel; slice k = storage[k-1][c].
  - Storage shifts: storage[k][c] <= storage[k-1][c], and storage[0][c] <= s_pixel.
  - A read and write to the same address in the same cycle returns old data.
- Row counter row_cnt saturates at NUM_LINES. m_rows_valid bit k = (row_cnt ≥ k); bit 0 is always 1 on a valid beat.
- Slices with rows_valid = 0 output all-zero.
- Column wrap:
  - On an accepted beat with s_eol, or with c == W-1, set c <= 0 and row_cnt++ (saturating).
  - Otherwise c++.
- err_line_len pulses on the cycle after an accept where s_eol != (c == W-1). Wrap still follows whichever event occurs first.
- s_sof accepted:
  - This beat is treated as c = 0, row 0: row_cnt is cleared and W is re-sampled.
  - All previous-row slices are flagged invalid.
  - If c != 0 at that time, err_line_len pulses (truncated line).
- m_sof / m_eol are registered copies of s_sof / the wrap condition.
- rst asserted mid-frame:
  - Next cycle: m_valid = 0 and counters = 0.
  - The in-flight output beat is dropped.
  - The first beat after reset is treated as row 0 even without s_sof.

Optional Feature:
- Macro: LB_BORDER_REPLICATE_EN.
- Defined: slices with rows_valid = 0 output the nearest valid row's pixel for that column (top-border replication; row 0 is replicated when only the current row exists). m_rows_valid is still reported truthfully.
- Undefined: invalid slices are zero, as described above.

Decomposition:
- Package line_buffer_pkg:
  - CW computation function.
  - Typedef pixel_t (DATA_WIDTH-wide; default 8).
  - Struct lb_ctrl_t {sof, eol}.
  - Enum for the error cause: ERR_NONE, ERR_SHORT, ERR_LONG, ERR_SOF_MIDLINE. Exposed internally for debug.
- One sub-module: lb_line_ram, a single-port read-before-write RAM of MAX_WIDTH × DATA_WIDTH, instantiated NUM_LINES times in a cascade.
- Top-level module holds the counters, handshake and output register.

Test Plan (MAX_WIDTH = 16, NUM_LINES = 2, cfg_width = 10):
1. Stream pixels 0..49 with s_sof on pixel 0, s_eol every 10th, m_ready = 1 → on pixel 25: m_column = {5, 15, 25}, m_rows_valid = 3'b111. On pixel 12: rows_valid = 3'b011, slice 2 = 0. No err_line_len.
2. Same stream, m_ready toggled 1/0 every cycle → identical output sequence, no beat lost or duplicated, s_ready low whenever m_valid && !m_ready.
3. s_eol asserted on pixel 7 of row 1 → err_line_len pulse. Next beat has column 0, row 2, and slice 1 reads the column-0 data of row 1.
4. s_sof asserted mid-row at column 4 → err_line_len pulse, m_rows_valid = 3'b001, following beats rebuild rows from 0.
5. rst pulsed for 1 cycle at pixel 23 → m_valid = 0 the next cycle. The first post-reset beat has m_rows_valid = 3'b001.
6. Build with LB_BORDER_REPLICATE_EN, run the scenario 1 stream → pixel 3: m_column = {3, 3, 3}; pixel 12: m_column = {2, 2, 12}.
